// File: rtl/sdram_tester.sv
// SDRAM self-test engine. It writes a pattern over a window of SDRAM words,
// reads the window back and compares it, and repeats that for a number of
// passes, inverting the pattern on odd passes. It reports the mismatch count,
// the first failing word and a pass/fail LED.
module sdram_tester #(
    parameter int ADDR_W        = 23,
    parameter int DATA_W        = 8,
    parameter int BASE_ADDR     = 'h1F800,
    parameter int LENGTH        = 1024,
    parameter int ACCESS_CYCLES = 8,
    parameter int PASSES        = 1
) (
    input  logic              i_f14m,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    output logic [ADDR_W-1:0] o_sdram_addr,
    output logic [DATA_W-1:0] o_sdram_din,
    output logic              o_sdram_we,
    output logic              o_sdram_oe,
    input  logic [DATA_W-1:0] i_sdram_dout,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass_ok,
    output logic [15:0]       o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [DATA_W-1:0] o_first_err_exp,
    output logic [DATA_W-1:0] o_first_err_got,
    output logic              o_led
);

    localparam int IDX_W = $clog2(LENGTH + 1);
    localparam int CYC_W = $clog2(ACCESS_CYCLES);
    localparam logic [15:0]       SEED      = 16'hACE1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LENGTH - 1);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(ACCESS_CYCLES - 1);
    localparam logic [31:0]       PASSES_U  = 32'(PASSES);

    typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_CHK, DONE} stateT;

    stateT             r_state;
    logic              r_startPrev;
    logic [1:0]        r_mode;
    logic [IDX_W-1:0]  r_idx;
    logic [CYC_W-1:0]  r_cyc;
    logic [31:0]       r_pass;
    logic [15:0]       r_lfsr;
    logic [DATA_W-1:0] r_rdData;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_we;
    logic              r_oe;
    logic              r_busy;
    logic              r_done;
    logic              r_passOk;
    logic [15:0]       r_errCount;
    logic [ADDR_W-1:0] r_firstErrAddr;
    logic [DATA_W-1:0] r_firstErrExp;
    logic [DATA_W-1:0] r_firstErrGot;

    logic              w_startEdge;
    logic [15:0]       w_lfsrStep;
    logic [31:0]       w_passNext;
    logic              w_morePasses;
    logic [DATA_W-1:0] w_patFirst;
    logic [DATA_W-1:0] w_patNextWr;
    logic [DATA_W-1:0] w_patNewPass;
    logic [DATA_W-1:0] w_patCheck;

    // Test pattern for one word: mode selects the generator, inv flips it on odd passes.
    function automatic logic [DATA_W-1:0] patternOf(input logic [1:0]        m,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic              inv,
                                                    input logic [DATA_W-1:0] lfsrLow);
        logic [DATA_W-1:0] p;
        logic [31:0]       idx32;
        idx32 = 32'(idx);
        p     = '0;
        case (m)
            2'd0: for (int b = 0; b < DATA_W; b++) p[b] = idx32[0] ^ ((b % 2) == 0);
            2'd1: p = idx32[DATA_W-1:0];
            2'd2: p = lfsrLow;
            default: p = DATA_W'(1) << (idx32 % 32'(DATA_W));
        endcase
        if (inv) p = ~p;
        return p;
    endfunction

    assign w_startEdge  = i_start & ~r_startPrev;
    assign w_lfsrStep   = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_passNext   = r_pass + 32'd1;
    assign w_morePasses = (PASSES == 0) || (w_passNext < PASSES_U);

    // Patterns needed at each point where a new access is launched or checked.
    assign w_patFirst   = patternOf(i_mode, '0, 1'b0, SEED[DATA_W-1:0]);
    assign w_patNextWr  = patternOf(r_mode, r_idx + 1'b1, r_pass[0], w_lfsrStep[DATA_W-1:0]);
    assign w_patNewPass = patternOf(r_mode, '0, w_passNext[0], SEED[DATA_W-1:0]);
    assign w_patCheck   = patternOf(r_mode, r_idx, r_pass[0], r_lfsr[DATA_W-1:0]);

    // Test sequencer: walks write sweeps then read/compare sweeps, all outputs registered.
    always_ff @(posedge i_f14m or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_startPrev    <= 1'b0;
            r_mode         <= 2'd0;
            r_idx          <= '0;
            r_cyc          <= '0;
            r_pass         <= '0;
            r_lfsr         <= SEED;
            r_rdData       <= '0;
            r_addr         <= '0;
            r_din          <= '0;
            r_we           <= 1'b0;
            r_oe           <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_passOk       <= 1'b0;
            r_errCount     <= '0;
            r_firstErrAddr <= '0;
            r_firstErrExp  <= '0;
            r_firstErrGot  <= '0;
        end else begin
            r_startPrev <= i_start;
            if ((r_state == IDLE || r_state == DONE) && w_startEdge) begin
                r_mode         <= i_mode;
                r_errCount     <= '0;
                r_firstErrAddr <= '0;
                r_firstErrExp  <= '0;
                r_firstErrGot  <= '0;
                r_done         <= 1'b0;
                r_passOk       <= 1'b0;
                r_pass         <= '0;
                r_idx          <= '0;
                r_cyc          <= '0;
                r_lfsr         <= SEED;
                r_busy         <= 1'b1;
                r_addr         <= BASE;
                r_din          <= w_patFirst;
                r_we           <= 1'b1;
                r_state        <= WR;
            end else begin
                case (r_state)
                    WR: begin
                        if (r_cyc == LAST_CYC) begin
                            r_we    <= 1'b0;
                            r_state <= WR_GAP;
                        end else begin
                            r_cyc <= r_cyc + 1'b1;
                        end
                    end
                    WR_GAP: begin
                        r_cyc <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_lfsr  <= SEED;
                            r_addr  <= BASE;
                            r_oe    <= 1'b1;
                            r_state <= RD;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_lfsr  <= w_lfsrStep;
                            r_addr  <= r_addr + 1'b1;
                            r_din   <= w_patNextWr;
                            r_we    <= 1'b1;
                            r_state <= WR;
                        end
                    end
                    RD: begin
                        if (r_cyc == LAST_CYC) begin
                            r_oe     <= 1'b0;
                            r_rdData <= i_sdram_dout;
                            r_state  <= RD_CHK;
                        end else begin
                            r_cyc <= r_cyc + 1'b1;
                        end
                    end
                    RD_CHK: begin
                        r_cyc <= '0;
                        if (r_rdData != w_patCheck) begin
                            if (r_errCount != 16'hFFFF) r_errCount <= r_errCount + 16'd1;
                            if (r_errCount == 16'd0) begin
                                r_firstErrAddr <= r_addr;
                                r_firstErrExp  <= w_patCheck;
                                r_firstErrGot  <= r_rdData;
                            end
                        end
                        if (r_idx == LAST_IDX) begin
                            r_pass <= w_passNext;
                            if (w_morePasses) begin
                                r_idx   <= '0;
                                r_lfsr  <= SEED;
                                r_addr  <= BASE;
                                r_din   <= w_patNewPass;
                                r_we    <= 1'b1;
                                r_state <= WR;
                            end else begin
                                r_state <= DONE;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_lfsr  <= w_lfsrStep;
                            r_addr  <= r_addr + 1'b1;
                            r_oe    <= 1'b1;
                            r_state <= RD;
                        end
                    end
                    DONE: begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_passOk <= (r_errCount == 16'd0);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_sdram_addr     = r_addr;
    assign o_sdram_din      = r_din;
    assign o_sdram_we       = r_we;
    assign o_sdram_oe       = r_oe;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass_ok        = r_passOk;
    assign o_err_count      = r_errCount;
    assign o_first_err_addr = r_firstErrAddr;
    assign o_first_err_exp  = r_firstErrExp;
    assign o_first_err_got  = r_firstErrGot;
    assign o_led            = ~(r_done & r_passOk);

endmodule

// File: tb/tb_sdram_tester.sv
// Bench for sdram_tester: a small RAM with 2-cycle read latency and an optional
// stuck-at bit, and a reference model of a whole run built from the pattern rules.
module tb_sdram_tester;

   localparam int ADDR_W     = 23;
   localparam int DATA_W     = 8;
   localparam int LENGTH     = 4;
   localparam int AC         = 3;
   localparam int PASSES     = 2;
   localparam int RUN_CYCLES = 1 + PASSES * 2 * LENGTH * (AC + 1);
   localparam int BUDGET     = 400;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] sdramAddr;
   logic [DATA_W-1:0] sdramDin;
   logic              sdramWe;
   logic              sdramOe;
   logic [DATA_W-1:0] sdramDout;
   logic              busy;
   logic              done;
   logic              passOk;
   logic [15:0]       errCount;
   logic [ADDR_W-1:0] firstErrAddr;
   logic [DATA_W-1:0] firstErrExp;
   logic [DATA_W-1:0] firstErrGot;
   logic              led;

   int compareCount = 0;
   int failCount    = 0;

   logic [7:0]        mem [LENGTH];
   logic [7:0]        rdPipe;
   bit                faultEn;
   int                faultAddr;
   int                faultBit;
   logic              faultVal;
   logic [ADDR_W-1:0] wrAddrQ [$];
   logic [7:0]        wrDataQ [$];
   logic              wePrev = 1'b0;
   int                overlapCount = 0;
   int                cycles;

   sdram_tester #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0), .LENGTH(LENGTH),
      .ACCESS_CYCLES(AC), .PASSES(PASSES)
   ) dut (
      .i_f14m(clk), .i_reset(reset), .i_start(start), .i_mode(mode),
      .o_sdram_addr(sdramAddr), .o_sdram_din(sdramDin), .o_sdram_we(sdramWe),
      .o_sdram_oe(sdramOe), .i_sdram_dout(sdramDout), .o_busy(busy), .o_done(done),
      .o_pass_ok(passOk), .o_err_count(errCount), .o_first_err_addr(firstErrAddr),
      .o_first_err_exp(firstErrExp), .o_first_err_got(firstErrGot), .o_led(led)
   );

   always #5 clk = ~clk;

   // Word as stored by the RAM, including the optional stuck-at bit.
   function automatic logic [7:0] stuck(input logic [7:0] d, input int a);
      logic [7:0] v;
      v = d;
      if (faultEn && a == faultAddr) v[faultBit] = faultVal;
      return v;
   endfunction

   // Expected pattern for word i of pass p.
   function automatic logic [7:0] modelPat(input int m, input int p, input int i);
      logic [15:0] l;
      logic [7:0]  v;
      case (m)
         0: v = (i % 2 == 1) ? 8'hAA : 8'h55;
         1: v = 8'(i);
         2: begin
            l = 16'hACE1;
            for (int k = 0; k < i; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
            v = l[7:0];
         end
         default: v = 8'(1 << (i % 8));
      endcase
      if (p % 2 == 1) v = ~v;
      return v;
   endfunction

   // RAM: writes land with the fault applied, reads appear two cycles after oe.
   always @(posedge clk) begin
      if (sdramWe) mem[sdramAddr[1:0]] <= stuck(sdramDin, int'(sdramAddr[1:0]));
      rdPipe    <= sdramOe ? mem[sdramAddr[1:0]] : 8'hEE;
      sdramDout <= rdPipe;
   end

   // Monitor: logs each write access once and counts we/oe overlap.
   always @(negedge clk) begin
      if (sdramWe && !wePrev) begin
         wrAddrQ.push_back(sdramAddr);
         wrDataQ.push_back(sdramDin);
      end
      if (sdramWe && sdramOe) overlapCount <= overlapCount + 1;
      wePrev <= sdramWe;
   end

   task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Launches one run and waits (bounded) for done; optionally pulses start mid-run.
   task automatic applyStimulus(input int m, input bit fEn, input int fAddr, input int fBit,
                                input logic fVal, input int pulseAt, input int altMode);
      faultEn   = fEn;
      faultAddr = fAddr;
      faultBit  = fBit;
      faultVal  = fVal;
      wrAddrQ.delete();
      wrDataQ.delete();
      mode = 2'(m);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      cycles = 0;
      #2 start = 1'b0;
      while (done !== 1'b1 && cycles < BUDGET) begin
         @(posedge clk);
         cycles++;
         #1;
         if (cycles == pulseAt) begin
            start = 1'b1;
            mode  = 2'(altMode);
         end
         if (cycles == pulseAt + 2) start = 1'b0;
      end
   endtask

   // Builds the expected run from the pattern rules and compares every result.
   task automatic checkOutput(input string tag, input int m);
      logic [7:0] mm [LENGTH];
      logic [7:0] expW [PASSES*LENGTH];
      logic [7:0] w;
      int errs = 0;
      int fA = 0;
      logic [7:0] fE = 8'h00;
      logic [7:0] fG = 8'h00;
      for (int p = 0; p < PASSES; p++) begin
         for (int i = 0; i < LENGTH; i++) begin
            w = modelPat(m, p, i);
            expW[p*LENGTH+i] = w;
            mm[i] = stuck(w, i);
         end
         for (int i = 0; i < LENGTH; i++) begin
            w = modelPat(m, p, i);
            if (mm[i] !== w) begin
               if (errs == 0) begin
                  fA = i;
                  fE = w;
                  fG = mm[i];
               end
               errs++;
            end
         end
      end
      compare({tag, ".cycles"}, 32'(cycles), 32'(RUN_CYCLES));
      compare({tag, ".done"}, 32'(done), 32'd1);
      compare({tag, ".busy"}, 32'(busy), 32'd0);
      compare({tag, ".passOk"}, 32'(passOk), 32'(errs == 0));
      compare({tag, ".led"}, 32'(led), 32'(errs != 0));
      compare({tag, ".errCount"}, 32'(errCount), 32'(errs));
      compare({tag, ".firstErrAddr"}, 32'(firstErrAddr), 32'(fA));
      compare({tag, ".firstErrExp"}, 32'(firstErrExp), 32'(fE));
      compare({tag, ".firstErrGot"}, 32'(firstErrGot), 32'(fG));
      compare({tag, ".writes"}, 32'(wrDataQ.size()), 32'(PASSES * LENGTH));
      for (int k = 0; k < PASSES * LENGTH && k < wrDataQ.size(); k++) begin
         compare($sformatf("%s.wrAddr%0d", tag, k), 32'(wrAddrQ[k]), 32'(k % LENGTH));
         compare($sformatf("%s.wrData%0d", tag, k), 32'(wrDataQ[k]), 32'(expW[k]));
      end
      compare({tag, ".overlap"}, 32'(overlapCount), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 2'd0;
      faultEn = 1'b0;
      faultAddr = 0;
      faultBit = 0;
      faultVal = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compare("rst.busy", 32'(busy), 32'd0);
      compare("rst.done", 32'(done), 32'd0);
      compare("rst.passOk", 32'(passOk), 32'd0);
      compare("rst.errCount", 32'(errCount), 32'd0);
      compare("rst.we", 32'(sdramWe), 32'd0);
      compare("rst.oe", 32'(sdramOe), 32'd0);
      compare("rst.addr", 32'(sdramAddr), 32'd0);
      compare("rst.din", 32'(sdramDin), 32'd0);
      compare("rst.firstErrAddr", 32'(firstErrAddr), 32'd0);
      compare("rst.led", 32'(led), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Address-as-data on clean RAM.
      applyStimulus(1, 1'b0, 0, 0, 1'b0, -10, 0);
      checkOutput("s1", 1);
      compare("s1.wr3", 32'(wrDataQ[3]), 32'h03);
      compare("s1.led", 32'(led), 32'd0);

      // Alternating pattern with bit2 of word 2 stuck low.
      applyStimulus(0, 1'b1, 2, 2, 1'b0, -10, 0);
      checkOutput("s2", 0);
      compare("s2.errCount", 32'(errCount), 32'd1);
      compare("s2.firstErrAddr", 32'(firstErrAddr), 32'd2);
      compare("s2.firstErrExp", 32'(firstErrExp), 32'h55);
      compare("s2.firstErrGot", 32'(firstErrGot), 32'h51);
      compare("s2.led", 32'(led), 32'd1);

      // Alternating pattern, second pass inverted.
      applyStimulus(0, 1'b0, 0, 0, 1'b0, -10, 0);
      checkOutput("s3", 0);
      compare("s3.wr1", 32'(wrDataQ[1]), 32'hAA);
      compare("s3.wr4", 32'(wrDataQ[4]), 32'hAA);

      // LFSR pattern.
      applyStimulus(2, 1'b0, 0, 0, 1'b0, -10, 0);
      checkOutput("s4", 2);
      compare("s4.wr0", 32'(wrDataQ[0]), 32'hE1);
      compare("s4.wr1", 32'(wrDataQ[1]), 32'h70);
      compare("s4.wr2", 32'(wrDataQ[2]), 32'h38);

      // Reset in the middle of a write access.
      mode = 2'd1;
      @(negedge clk);
      start = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      compare("s5.weBefore", 32'(sdramWe), 32'd1);
      #1 reset = 1'b1;
      #1;
      compare("s5.we", 32'(sdramWe), 32'd0);
      compare("s5.oe", 32'(sdramOe), 32'd0);
      compare("s5.busy", 32'(busy), 32'd0);
      compare("s5.errCount", 32'(errCount), 32'd0);
      compare("s5.led", 32'(led), 32'd1);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1, 1'b0, 0, 0, 1'b0, -10, 0);
      checkOutput("s5b", 1);

      // Start pulse and mode change while busy are ignored.
      applyStimulus(1, 1'b0, 0, 0, 1'b0, 10, 3);
      checkOutput("s6", 1);

      // Random modes and random stuck-at faults.
      for (int r = 0; r < 6; r++) begin
         int  m;
         bit  fEn;
         int  fAddr;
         int  fBit;
         logic fVal;
         m     = int'($urandom_range(0, 3));
         fEn   = 1'($urandom_range(0, 1));
         fAddr = int'($urandom_range(0, LENGTH - 1));
         fBit  = int'($urandom_range(0, 7));
         fVal  = 1'($urandom_range(0, 1));
         applyStimulus(m, fEn, fAddr, fBit, fVal, -10, 0);
         checkOutput($sformatf("rnd%0d", r), m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
